// File: rtl/fir_out_fifo.sv
// FIR output sample queue: first-word-fall-through FIFO with sticky overflow flag.
// Optional peak-magnitude tracker enabled by defining FIR_OUT_FIFO_PEAK_EN.
module fir_out_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk_filter,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              overflow
`ifdef FIR_OUT_FIFO_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full, push, pop, drop;

    always_comb begin
        out_valid = (count_q != '0);
        full      = (count_q == FULL_CNT);
        pop       = out_valid && out_ready;
        // A pop frees the head slot this cycle, so a full queue can still accept.
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk_filter or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset; occupancy alone defines validity.
    always_ff @(posedge clk_filter) begin
        if (push && rst_n)
            mem_q[wr_ptr_q] <= in_data;
    end

    always_comb begin
        out_data = out_valid ? mem_q[rd_ptr_q] : '0;
        count    = count_q;
        overflow = overflow_q;
    end

`ifdef FIR_OUT_FIFO_PEAK_EN
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] peak_q, peak_d, mag;

    always_comb begin
        // Most-negative input has no positive counterpart; clamp it.
        if (!in_data[DATA_W-1])
            mag = in_data;
        else if (in_data == MIN_NEG)
            mag = MAX_POS;
        else
            mag = -in_data;

        peak_d = peak_q;
        if (clr)
            peak_d = '0;
        else if (push && (mag > peak_q))
            peak_d = mag;
    end

    always_ff @(posedge clk_filter or negedge rst_n) begin
        if (!rst_n)
            peak_q <= '0;
        else
            peak_q <= peak_d;
    end

    always_comb peak = peak_q;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Scoreboard bench for fir_out_fifo; peak checks compile in with FIR_OUT_FIFO_PEAK_EN.
module tb_fir_out_fifo;

    localparam int DW = 16;
    localparam int DP = 8;

    logic          clk_filter = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          clr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    count;
    logic          overflow;
`ifdef FIR_OUT_FIFO_PEAK_EN
    logic [DW-1:0] peak;
`endif

    fir_out_fifo #(.DATA_W(DW), .DEPTH(DP), .AW(3)) dut (
        .clk_filter (clk_filter),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .clr        (clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow)
`ifdef FIR_OUT_FIFO_PEAK_EN
        ,
        .peak       (peak)
`endif
    );

    always #5 clk_filter = ~clk_filter;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [DW-1:0] exp_q [$];
    logic          m_ovf  = 1'b0;
    logic [DW-1:0] m_peak = '0;
    logic [DW-1:0] last_pop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return DW'(v);
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        chk({tag, "_data"}, 32'(out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef FIR_OUT_FIFO_PEAK_EN
        chk({tag, "_peak"}, 32'(peak), 32'(m_peak));
`endif
    endtask

    // One clock of traffic; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic rdy, input logic c, input string tag);
        logic was_full, do_pop, do_push;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        clr       = c;
        #1;
        was_full = (exp_q.size() == DP);
        do_pop   = rdy && (exp_q.size() != 0);
        do_push  = iv && (!was_full || do_pop);
        if (do_pop) begin
            chk({tag, "_pop"}, 32'(out_data), 32'(exp_q[0]));
            last_pop = exp_q.pop_front();
        end
        if (do_push) exp_q.push_back(d);
        if (iv && was_full && !do_pop) m_ovf = 1'b1;
        else if (c)                    m_ovf = 1'b0;
        if (c)                                    m_peak = '0;
        else if (do_push && abs_sat(d) > m_peak)  m_peak = abs_sat(d);
        @(posedge clk_filter);
        #1;
        check_state(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_peak = '0;
    endtask

    initial begin
        logic [DW-1:0] seq [8];
        seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_filter);
        #1;
        check_state("reset");
        @(negedge clk_filter) rst_n = 1'b1;
        @(posedge clk_filter);
        #1;

        // Fill, then overflow attempt, then drain in order.
        foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0, "fill");
        chk("full_head", 32'(out_data), 32'd1);
        step(1'b1, 16'd0, 1'b0, 1'b0, "drop");
        chk("drop_ovf", 32'(overflow), 32'd1);
        repeat (DP) step(1'b0, 16'd0, 1'b1, 1'b0, "drain");
        chk("drain_last", 32'(last_pop), 32'd9);
        step(1'b0, 16'd0, 1'b1, 1'b0, "empty_rdy");

        // Full queue with simultaneous push and pop.
        foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0, "refill");
        step(1'b1, 16'd5, 1'b1, 1'b0, "full_pp");
        chk("full_pp_count", 32'(count), 32'd8);
        repeat (DP) step(1'b0, 16'd0, 1'b1, 1'b0, "drain2");
        chk("last_is_5", 32'(last_pop), 32'd5);

        // clr alone clears; clr with a drop keeps the flag set.
        step(1'b0, 16'd0, 1'b0, 1'b1, "clr");
        foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0, "fill3");
        step(1'b1, 16'd77, 1'b0, 1'b1, "clr_drop");
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        step(1'b0, 16'd0, 1'b0, 1'b1, "clr2");
        repeat (DP) step(1'b0, 16'd0, 1'b1, 1'b0, "drain3");

        // Push and pop on empty is push only.
        step(1'b1, 16'h1234, 1'b1, 1'b0, "pp_empty");
        chk("pp_empty_data", 32'(out_data), 32'h1234);
        step(1'b0, 16'd0, 1'b1, 1'b0, "pp_drain");

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 40) == 0), "rand");
        repeat (12) step(1'b0, 16'd0, 1'b1, 1'b0, "rand_drain");

        // Asynchronous reset mid-burst with five queued samples and overflow set.
        foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0, "fill4");
        step(1'b1, 16'd0, 1'b0, 1'b0, "drop4");
        repeat (3) step(1'b0, 16'd0, 1'b1, 1'b0, "to5");
        chk("pre_rst_count", 32'(count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        check_state("async_rst");
        in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1; clr = 1'b1;
        @(posedge clk_filter);
        #1;
        check_state("rst_hold");
        @(negedge clk_filter);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk_filter);
        #1;
        step(1'b1, 16'h00AA, 1'b0, 1'b0, "post_rst");
        step(1'b0, 16'd0, 1'b1, 1'b0, "post_rst_pop");

`ifdef FIR_OUT_FIFO_PEAK_EN
        step(1'b0, 16'd0, 1'b0, 1'b1, "pk_clr0");
        step(1'b1, 16'h0010, 1'b0, 1'b0, "pk1");
        chk("peak1", 32'(peak), 32'h0010);
        step(1'b1, 16'hFFF0, 1'b0, 1'b0, "pk2");
        chk("peak2", 32'(peak), 32'h0010);
        step(1'b1, 16'h8000, 1'b0, 1'b0, "pk3");
        chk("peak3", 32'(peak), 32'h7FFF);
        step(1'b1, 16'h0005, 1'b0, 1'b0, "pk4");
        chk("peak4", 32'(peak), 32'h7FFF);
        step(1'b0, 16'd0, 1'b0, 1'b1, "pk_clr");
        chk("peak_clr", 32'(peak), 32'h0000);
        step(1'b1, 16'h0100, 1'b0, 1'b1, "pk_clr_push");
        chk("peak_clr_push", 32'(peak), 32'h0000);
        repeat (6) step(1'b0, 16'd0, 1'b1, 1'b0, "pk_drain");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_out_fifo.md
FIR_OUT_FIFO -- requirements
Module: fir_out_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries, power of 2, ≥2.
REQ-003 SHALL have parameter AW, default 3, pointer width = log2(DEPTH).
REQ-004 SHALL have port clk_filter  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  DATA_W  filter output sample (the FIR out_data).
REQ-007 SHALL have port in_valid  input  1  in_data holds a new sample this cycle.
REQ-008 SHALL have port clr  input  1  synchronous clear of overflow flag and peak register.
REQ-009 SHALL have port out_data  output  DATA_W  head-of-queue sample.
REQ-010 SHALL have port out_valid  output  1  queue non-empty.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head this cycle.
REQ-012 SHALL have port count  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a sample was dropped.
REQ-014 SHALL have port peak  output  DATA_W  max |sample| accepted since reset/clr (only with FIR_OUT_FIFO_PEAK_EN).

Function
REQ-015 SHALL push in_data when in_valid=1 and (count<DEPTH or pop occurs in the same cycle).
REQ-016 SHALL pop when out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-017 SHALL be first-word-fall-through: out_data = memory[rd_ptr] combinationally when out_valid=1, all-zero when out_valid=0.
REQ-018 SHALL raise out_valid on the cycle after the first push into an empty queue (latency 1); push+pop on empty is push only.
REQ-019 SHALL keep count unchanged on simultaneous push and pop, including when count=DEPTH.
REQ-020 SHALL wrap wr_ptr and rd_ptr modulo DEPTH with no gap or repeat.
REQ-021 SHALL drop in_data when in_valid=1, count=DEPTH and no pop, and set overflow=1 on the next edge.
REQ-022 SHALL hold overflow at 1 until clr=1 or reset; clr and a new drop in the same cycle SHALL leave overflow=1.
REQ-023 SHALL preserve sample order exactly; data SHALL pass unmodified (no rounding or saturation).

Reset
REQ-024 SHALL on rst_n=0, asynchronously: rd_ptr=0, wr_ptr=0, count=0, out_valid=0, out_data=0, overflow=0, peak=0.
REQ-025 SHALL NOT reset memory contents; reset mid-operation discards all queued samples.
REQ-026 SHALL ignore in_valid, out_ready and clr while rst_n=0 and accept them on the first edge after release.

Configuration
REQ-027 SHALL include the peak tracker and peak port only when macro FIR_OUT_FIFO_PEAK_EN is defined.
REQ-028 SHALL with FIR_OUT_FIFO_PEAK_EN: on each accepted push, peak <= max(peak, |in_data|), |−2^(DATA_W−1)| saturated to 2^(DATA_W−1)−1; clr sets peak=0, push in the clr cycle SHALL be ignored by the tracker.
REQ-029 SHALL without FIR_OUT_FIFO_PEAK_EN: no peak port, no peak logic; all other behaviour identical.

Verification
REQ-030 SHALL test: reset, push 1,2,3,4,6,7,8,9 with out_ready=0 -> count=8, overflow=0, out_data=1.
REQ-031 SHALL test: then push 0 with out_ready=0 -> count stays 8, overflow=1; pop all -> 1,2,3,4,6,7,8,9 in order, out_valid=0, out_data=0.
REQ-032 SHALL test: full queue, in_valid=1 (data 5) with out_ready=1 -> count=8, overflow unchanged, 5 is last word read out.
REQ-033 SHALL test: empty queue, in_valid=1 (data 0x1234) and out_ready=1 same cycle -> next cycle out_valid=1, out_data=0x1234, count=1.
REQ-034 SHALL test: rst_n low mid-burst with count=5 -> count=0, out_valid=0, overflow=0 immediately, before next clock edge.
REQ-035 SHALL test (PEAK_EN): push 0x0010, 0xFFF0, 0x8000, 0x0005 -> peak 0x0010, 0x0010, 0x7FFF, 0x7FFF; clr -> peak=0x0000.
